// File: rtl/uart_peripheral.sv
// Memory-mapped UART: control/data registers, independent TX and RX FSMs, 8N1 by default.
// Define UART_PARITY_EN to add an even-parity bit to both directions.
module uart_peripheral #(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_ctrl_i,
    input  logic        we_data_i,
    input  logic [31:0] data_i,
    input  logic        rx_i,
    output logic        tx_o,
    output logic [31:0] out_ctrl_o,
    output logic [31:0] out_data_o
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    state_e             tx_state_q, rx_state_q;
    logic [CNT_W-1:0]   tx_cnt_q, rx_cnt_q;
    logic [2:0]         tx_idx_q, rx_idx_q;
    logic [7:0]         tx_shift_q, tx_hold_q, rx_shift_q, rx_byte_q;
    logic               tx_q, rx_s1_q, rx_s2_q, rx_prev_q;
    logic               send_q, rx_new_q, frame_err_q, par_err_q;
    logic               send_d, rx_new_d, frame_err_d, par_err_d;
    logic               tx_done, rx_stop_mid, rx_good, frame_set, par_set, par_ok;
    logic               unused_bits;

    assign unused_bits = ^data_i[31:8];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tx_hold_q <= 8'h00;
        else if (we_data_i) tx_hold_q <= data_i[7:0];
    end

`ifdef UART_PARITY_EN
    logic tx_par_q, rx_par_ok_q;
    assign par_ok = rx_par_ok_q;
`else
    assign par_ok = 1'b1;
`endif

    // TX: tx_q is registered so reset returns the line to idle with no clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else if (tx_state_q == S_IDLE) begin
            tx_q <= 1'b1;
            if (send_q) begin
                tx_shift_q <= tx_hold_q;
                tx_q       <= 1'b0;
                tx_cnt_q   <= '0;
                tx_state_q <= S_START;
`ifdef UART_PARITY_EN
                tx_par_q   <= ^tx_hold_q;
`endif
            end
        end else if (tx_cnt_q != BIT_LAST) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_q <= '0;
            case (tx_state_q)
                S_START: begin
                    tx_state_q <= S_DATA;
                    tx_idx_q   <= '0;
                    tx_q       <= tx_shift_q[0];
                end
                S_DATA: begin
                    if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_q <= S_PAR;
                        tx_q       <= tx_par_q;
`else
                        tx_state_q <= S_STOP;
                        tx_q       <= 1'b1;
`endif
                    end else begin
                        tx_idx_q   <= tx_idx_q + 1'b1;
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_q       <= tx_shift_q[1];
                    end
                end
`ifdef UART_PARITY_EN
                S_PAR: begin
                    tx_state_q <= S_STOP;
                    tx_q       <= 1'b1;
                end
`endif
                default: begin
                    tx_state_q <= S_IDLE;
                    tx_q       <= 1'b1;
                end
            endcase
        end
    end

    assign tx_done = (tx_state_q == S_STOP) && (tx_cnt_q == BIT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // RX: half-bit wait in START lands every later sample at mid-bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
`ifdef UART_PARITY_EN
            rx_par_ok_q <= 1'b1;
`endif
        end else if (rx_state_q == S_IDLE) begin
            if (rx_prev_q && !rx_s2_q) begin
                rx_state_q <= S_START;
                rx_cnt_q   <= '0;
            end
        end else if (rx_state_q == S_START) begin
            if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_q   <= '0;
                rx_idx_q   <= '0;
                rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
            end else begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end
        end else if (rx_cnt_q != BIT_LAST) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
        end else begin
            rx_cnt_q <= '0;
            case (rx_state_q)
                S_DATA: begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                    rx_idx_q   <= rx_idx_q + 1'b1;
                    if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_q <= S_PAR;
`else
                        rx_state_q <= S_STOP;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                S_PAR: begin
                    rx_par_ok_q <= ((^rx_shift_q) == rx_s2_q);
                    rx_state_q  <= S_STOP;
                end
`endif
                default: begin
                    rx_state_q <= S_IDLE;
                    if (rx_good) rx_byte_q <= rx_shift_q;
                end
            endcase
        end
    end

    assign rx_stop_mid = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_LAST);
    assign rx_good     = rx_stop_mid && rx_s2_q && par_ok;
    assign frame_set   = rx_stop_mid && !rx_s2_q;
    assign par_set     = rx_stop_mid && rx_s2_q && !par_ok;

    // Flags: software may only clear, hardware set takes priority.
    always_comb begin
        send_d      = send_q;
        rx_new_d    = rx_new_q;
        frame_err_d = frame_err_q;
        par_err_d   = par_err_q;
        if (tx_done) send_d = 1'b0;
        else if (we_ctrl_i && data_i[0] && tx_state_q == S_IDLE) send_d = 1'b1;
        if (we_ctrl_i && !data_i[1]) rx_new_d    = 1'b0;
        if (we_ctrl_i && !data_i[2]) frame_err_d = 1'b0;
        if (we_ctrl_i && !data_i[3]) par_err_d   = 1'b0;
        if (rx_good)   rx_new_d    = 1'b1;
        if (frame_set) frame_err_d = 1'b1;
        if (par_set)   par_err_d   = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            send_q      <= 1'b0;
            rx_new_q    <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            send_q      <= send_d;
            rx_new_q    <= rx_new_d;
            frame_err_q <= frame_err_d;
`ifdef UART_PARITY_EN
            par_err_q   <= par_err_d;
`else
            par_err_q   <= 1'b0;
`endif
        end
    end

    assign tx_o       = tx_q;
    assign out_ctrl_o = {28'h0, par_err_q, frame_err_q, rx_new_q, send_q};
    assign out_data_o = {24'h0, rx_byte_q};
endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral at 10 clocks per bit; parity checks under UART_PARITY_EN.
module tb_uart_peripheral;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst, we_ctrl, we_data, rx_drv, loop_en;
    logic [31:0] din;
    logic        tx, rx_w;
    logic [31:0] ctrl, dout;
    int          nvec = 0;
    int          nmis = 0;

    always #5 clk = ~clk;
    assign rx_w = loop_en ? tx : rx_drv;

    uart_peripheral #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk_i(clk), .rst_i(rst), .we_ctrl_i(we_ctrl), .we_data_i(we_data),
        .data_i(din), .rx_i(rx_w), .tx_o(tx), .out_ctrl_o(ctrl), .out_data_o(dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_data(input logic [7:0] b);
        din = {24'h0, b}; we_data = 1'b1;
        tick();
        we_data = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        din = v; we_ctrl = 1'b1;
        tick();
        we_ctrl = 1'b0;
    endtask

    // Expected line level for frame slot i: start, 8 data LSB first, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic rx_frame(input logic [7:0] b, input logic p, input logic s);
        rx_drv = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (10) tick();
        end
`ifdef UART_PARITY_EN
        rx_drv = p;
        repeat (10) tick();
`else
        if (p === 1'bx) rx_drv = 1'b1;
`endif
        rx_drv = s;
        repeat (10) tick();
        rx_drv = 1'b1;
    endtask

    task automatic tx_scan(input logic [7:0] b, input string tag);
        wr_data(b);
        wr_ctrl(32'h1);
        chk({tag, "_send_set"}, ctrl, 32'h1);
        chk({tag, "_idle_edgeN"}, {31'b0, tx}, 32'h1);
        for (int t = 1; t <= NBITS * 10 + 1; t++) begin
            tick();
            if (t % 10 == 5) chk({tag, "_bit"}, {31'b0, tx}, {31'b0, exp_bit(b, t / 10)});
            if (t == NBITS * 10) chk({tag, "_send_last"}, {31'b0, ctrl[0]}, 32'h1);
        end
        chk({tag, "_send_clr"}, ctrl, 32'h0);
        chk({tag, "_tx_idle"}, {31'b0, tx}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; we_ctrl = 1'b0; we_data = 1'b0; din = '0;
        rx_drv = 1'b1; loop_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, tx}, 32'h1);
        chk("rst_ctrl", ctrl, 32'h0);
        chk("rst_data", dout, 32'h0);
        rst = 1'b0;
        tick();

        tx_scan(8'h55, "tx55");
        wr_ctrl(32'hE);
        chk("w1_noset", ctrl, 32'h0);

        loop_en = 1'b1;
        wr_data(8'hA3);
        wr_ctrl(32'h1);
        for (int t = 1; t <= NBITS * 10 + 5; t++) begin
            tick();
            if (t == NBITS * 10 - 5) chk("lb_early", dout, 32'h0);
        end
        chk("lb_data", dout, 32'h0000_00A3);
        chk("lb_ctrl", ctrl, 32'h2);
        wr_ctrl(32'h2);
        chk("w1_keep", ctrl, 32'h2);
        wr_ctrl(32'h0);
        chk("lb_clr", ctrl, 32'h0);
        loop_en = 1'b0;

        rx_drv = 1'b0;
        repeat (3) tick();
        rx_drv = 1'b1;
        repeat (30) tick();
        chk("glitch_ctrl", ctrl, 32'h0);
        chk("glitch_data", dout, 32'h0000_00A3);

        rx_frame(8'h5A, ^8'h5A, 1'b1);
        repeat (5) tick();
        chk("rx5a_data", dout, 32'h0000_005A);
        chk("rx5a_ctrl", ctrl, 32'h2);
        wr_ctrl(32'h0);

        rx_frame(8'h3C, ^8'h3C, 1'b0);
        repeat (5) tick();
        chk("ferr_ctrl", ctrl, 32'h4);
        chk("ferr_data", dout, 32'h0000_005A);
        wr_ctrl(32'h0);
        chk("ferr_clr", ctrl, 32'h0);

`ifdef UART_PARITY_EN
        tx_scan(8'hA3, "txA3p");
        rx_frame(8'hA3, 1'b1, 1'b1);
        repeat (5) tick();
        chk("perr_ctrl", ctrl, 32'h8);
        chk("perr_data", dout, 32'h0000_005A);
        wr_ctrl(32'h0);
`endif

        // Mid-frame: ignored SEND/data rewrite at clock 35, async reset at clock 50.
        wr_data(8'h55);
        wr_ctrl(32'h1);
        for (int t = 1; t <= 50; t++) begin
            if (t == 35) begin
                din = 32'hFF; we_ctrl = 1'b1; we_data = 1'b1;
            end
            tick();
            we_ctrl = 1'b0; we_data = 1'b0;
            if (t % 10 == 5) chk("mid_bit", {31'b0, tx}, {31'b0, exp_bit(8'h55, t / 10)});
            if (t == 45) chk("mid_ctrl", ctrl, 32'h1);
        end
        chk("pre_rst_tx", {31'b0, tx}, {31'b0, exp_bit(8'h55, 4)});
        rst = 1'b1;
        #1;
        chk("arst_tx", {31'b0, tx}, 32'h1);
        chk("arst_ctrl", ctrl, 32'h0);
        chk("arst_data", dout, 32'h0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("post_rst_tx", {31'b0, tx}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
